// File: rtl/fir_interp_pkg.sv
// Shared fixed-point helpers and the default coefficient table for the
// polyphase interpolating FIR.
package fir_interp_pkg;

  // Sample/coefficient/accumulator width and fractional bits of the
  // quantized format.
  localparam int DATA_W       = 32;
  localparam int QUANT_BITS   = 10;

  // Default filter geometry.
  localparam int DEFAULT_TAPS = 32;
  localparam int DEFAULT_L    = 4;

  // Default interpolation taps h[0..31], symmetric low-pass, scaled by
  // 2^QUANT_BITS.
  localparam logic signed [DATA_W-1:0] DEFAULT_COEFF [DEFAULT_TAPS] = '{
    -2,   -5,   -9,  -10,   -3,   16,   42,   62,
    56,    7,  -80, -170, -210, -120,  160,  620,
    620,  160, -120, -210, -170,  -80,    7,   56,
    62,   42,   16,   -3,  -10,   -9,   -5,   -2
  };

  // Signed divide by 2^QUANT_BITS rounding toward zero: negative values are
  // biased up by (2^QUANT_BITS - 1) before the arithmetic shift so the
  // shift's floor behaviour becomes truncation.
  function automatic logic signed [DATA_W-1:0] dequantize(
    input logic signed [DATA_W-1:0] v
  );
    logic signed [DATA_W-1:0] bias;
    bias = v[DATA_W-1] ? DATA_W'((1 << QUANT_BITS) - 1) : '0;
    return (v + bias) >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/fir_interp_mac.sv
// Combinational multiply / dequantize / accumulate step shared by the FIR
// filters: acc_o = acc_i + dequantize(low word of coeff_i * sample_i).
module fir_mac
  import fir_interp_pkg::*;
(
  input  logic signed [DATA_W-1:0] acc_i,
  input  logic signed [DATA_W-1:0] coeff_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] acc_o
);

  logic signed [DATA_W-1:0] prod_lo;

  // Product is evaluated in a DATA_W context, so only its low word is kept;
  // the accumulator add wraps naturally.
  always_comb begin
    prod_lo = coeff_i * sample_i;
    acc_o   = acc_i + dequantize(prod_lo);
  end

endmodule

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: pops one sample from the upstream FIFO, then
// produces INTERPOLATION outputs, each the dot product of one coefficient
// phase with the sample history, using a single shared MAC.
//
// Handshake: x_rd_en is a pop strobe, high only in S_LOAD when x_empty is
// low; the sample on x_in is consumed on that clock edge. y_wr_en is a push
// strobe, high only in S_WRITE when y_out_full is low; y_out is valid
// whenever y_wr_en is high and holds steady while the write is stalled.
// Both strobes are forced low while reset is high.
module fir_interp
  import fir_interp_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int TAPS          = DEFAULT_TAPS,
  parameter int INTERPOLATION = DEFAULT_L,
  parameter logic signed [DATA_WIDTH-1:0] COEFF [TAPS] = DEFAULT_COEFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic                  x_rd_en,
  input  logic                  x_empty,
  output logic [DATA_WIDTH-1:0] y_out,
  input  logic                  y_out_full,
  output logic                  y_wr_en
);

  // Taps per phase and counter widths.
  localparam int PT     = TAPS / INTERPOLATION;
  localparam int K_W    = (PT > 1) ? $clog2(PT) : 1;
  localparam int P_W    = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
  localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(PT - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(INTERPOLATION - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   hist_q [PT];
  logic signed [DATA_WIDTH-1:0]   hist_d [PT];
  logic [P_W-1:0]                 phase_q, phase_d;
  logic [K_W-1:0]                 k_q, k_d;
  logic signed [DATA_WIDTH-1:0]   sum_q, sum_d;

  logic [IDX_W-1:0]               coeff_idx;
  logic signed [DATA_WIDTH-1:0]   coeff_sel;
  logic signed [DATA_WIDTH-1:0]   hist_sel;
  logic signed [DATA_WIDTH-1:0]   mac_sum;

  // Operand selection for the current MAC: coefficient h[phase + k*L]
  // against history slot k.
  always_comb begin
    coeff_idx = IDX_W'(phase_q) + IDX_W'(k_q) * IDX_W'(INTERPOLATION);
    coeff_sel = COEFF[coeff_idx];
    hist_sel  = hist_q[k_q];
  end

  fir_mac u_mac (
    .acc_i    (sum_q),
    .coeff_i  (coeff_sel),
    .sample_i (hist_sel),
    .acc_o    (mac_sum)
  );

  // The running sum is the output word; it is stable throughout S_WRITE.
  assign y_out = sum_q;

  // Next-state logic and FIFO strobes.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    phase_d = phase_q;
    k_d     = k_q;
    sum_d   = sum_q;
    x_rd_en = 1'b0;
    y_wr_en = 1'b0;

    case (state_q)
      S_LOAD: begin
        x_rd_en = !x_empty;
        if (!x_empty) begin
          hist_d[0] = x_in;
          for (int i = 1; i < PT; i++) begin
            hist_d[i] = hist_q[i-1];
          end
          phase_d = '0;
          k_d     = '0;
          sum_d   = '0;
          state_d = S_MAC;
        end
      end

      S_MAC: begin
        sum_d = mac_sum;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_WRITE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      S_WRITE: begin
        y_wr_en = !y_out_full;
        if (!y_out_full) begin
          if (phase_q == P_LAST) begin
            state_d = S_LOAD;
          end else begin
            phase_d = phase_q + P_W'(1);
            k_d     = '0;
            sum_d   = '0;
            state_d = S_MAC;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase

    // No FIFO traffic on a reset cycle, whatever state we were in.
    if (reset) begin
      x_rd_en = 1'b0;
      y_wr_en = 1'b0;
    end
  end

  // State, history, phase, tap counter and accumulator registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_LOAD;
      phase_q <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      for (int i = 0; i < PT; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      phase_q <= phase_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: three instances with different coefficient
// sets share one stimulus/monitor path selected by sel.
module tb_fir_interp;

  localparam logic signed [31:0] C_IMP [32] = '{
    0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15,
    16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31
  };
  localparam logic signed [31:0] C_DC [32] = '{default: 32'sh100};
  localparam logic signed [31:0] C_TR [32] = '{0: 32'sd512, default: 32'sd0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [1:0]  sel = 2'd0;
  logic [31:0] x_in_c = 32'd0;
  logic        x_empty_c = 1'b1;
  logic        full_c = 1'b0;

  logic [2:0]  rd_a, wr_a, empty_a, full_a;
  logic [31:0] y_a [3];
  logic        rd_c, wr_c;
  logic [31:0] y_c;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      empty_a[i] = (sel == 2'(i)) ? x_empty_c : 1'b1;
      full_a[i]  = (sel == 2'(i)) ? full_c : 1'b0;
    end
    rd_c = rd_a[sel];
    wr_c = wr_a[sel];
    y_c  = y_a[sel];
  end

  fir_interp #(.COEFF(C_IMP)) u_imp (
    .clock(clk), .reset(reset), .x_in(x_in_c), .x_rd_en(rd_a[0]),
    .x_empty(empty_a[0]), .y_out(y_a[0]), .y_out_full(full_a[0]), .y_wr_en(wr_a[0])
  );
  fir_interp #(.COEFF(C_DC)) u_dc (
    .clock(clk), .reset(reset), .x_in(x_in_c), .x_rd_en(rd_a[1]),
    .x_empty(empty_a[1]), .y_out(y_a[1]), .y_out_full(full_a[1]), .y_wr_en(wr_a[1])
  );
  fir_interp #(.COEFF(C_TR)) u_tr (
    .clock(clk), .reset(reset), .x_in(x_in_c), .x_rd_en(rd_a[2]),
    .x_empty(empty_a[2]), .y_out(y_a[2]), .y_out_full(full_a[2]), .y_wr_en(wr_a[2])
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_miscmp = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int rd_t[$];
  int wr_t[$];

  // Monitor: strobes seen at the falling edge commit at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (rd_c) rd_t.push_back(cyc);
      if (wr_c) begin
        got_q.push_back(y_c);
        wr_t.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_miscmp++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Offer one sample; return after the pop has committed with x_empty high.
  task automatic feed(input logic [31:0] x, input string tag);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    x_in_c = x;
    x_empty_c = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_c) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_timeout({tag, ".read"});
    @(posedge clk); #1;
    x_empty_c = 1'b1;
  endtask

  task automatic wait_outs(input int n, input string tag);
    int c;
    c = 0;
    while (got_q.size() < n && c < 600) begin
      @(negedge clk);
      c++;
    end
    if (got_q.size() < n) fail_timeout({tag, ".writes"});
  endtask

  function automatic logic [3:0][31:0] pack4(input logic [31:0] a, b, c, d);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Expect exactly four writes with the given values, in order.
  task automatic collect_and_check(input string tag, input logic [3:0][31:0] exp);
    for (int j = 0; j < 4; j++) exp_q.push_back(exp[j]);
    wait_outs(4, tag);
    repeat (2) @(negedge clk);
    chk({tag, ".count"}, 32'(got_q.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (got_q.size() > 0) begin
        chk($sformatf("%s.y%0d", tag, j), got_q.pop_front(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]       inst;
    logic [31:0]      x;
    logic [3:0][31:0] y;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic [1:0] inst, input logic [31:0] x,
                                  input logic [31:0] y0, y1, y2, y3);
    vec_t v;
    v.inst = inst;
    v.x = x;
    v.y = pack4(y0, y1, y2, y3);
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    // Impulse: 1024 then zeros walks h[0..31] out in order.
    for (int n = 0; n < 8; n++) begin
      add_vec(2'd0, (n == 0) ? 32'd1024 : 32'd0,
              32'(4*n), 32'(4*n+1), 32'(4*n+2), 32'(4*n+3));
    end
    // DC: 0.25 taps, input 1.0; output grows by 256 per filled slot up to 2048.
    for (int n = 1; n <= 9; n++) begin
      v = 32'(256 * ((n > 8) ? 8 : n));
      add_vec(2'd1, 32'd1024, v, v, v, v);
    end
    // Truncation toward zero and low-word products, h[0] = 0.5.
    add_vec(2'd2, 32'd1,          32'd0,          0, 0, 0);
    add_vec(2'd2, 32'hFFFF_FFFF,  32'd0,          0, 0, 0);
    add_vec(2'd2, 32'hFFFF_F800,  32'hFFFF_FC00,  0, 0, 0);
    add_vec(2'd2, 32'd3,          32'd1,          0, 0, 0);
    add_vec(2'd2, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 0, 0);
    add_vec(2'd2, 32'h4000_0000,  32'd0,          0, 0, 0);
    add_vec(2'd2, 32'h0040_0001,  32'hFFE0_0001,  0, 0, 0);

    // ---- reset: strobes low even with data waiting, outputs zero ----
    x_in_c = 32'd1024;
    x_empty_c = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset.rd", {31'd0, rd_c}, 32'd0);
      chk("reset.wr", {31'd0, wr_c}, 32'd0);
    end
    for (int i = 0; i < 3; i++) chk($sformatf("reset.y%0d", i), y_a[i], 32'd0);
    x_empty_c = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      sel = vecs[i].inst;
      feed(vecs[i].x, $sformatf("vec%0d", i));
      collect_and_check($sformatf("vec%0d", i), vecs[i].y);
    end

    // ---- empty: no traffic while empty, first write 9 cycles after read ----
    sel = 2'd0;
    repeat (15) begin
      @(negedge clk);
      chk("empty.rd", {31'd0, rd_c}, 32'd0);
      chk("empty.wr", {31'd0, wr_c}, 32'd0);
    end
    rd_t.delete();
    wr_t.delete();
    feed(32'd1024, "empty");
    collect_and_check("empty", pack4(0, 1, 2, 3));
    if (rd_t.size() > 0 && wr_t.size() > 0)
      chk("empty.latency", 32'(wr_t[0] - rd_t[0]), 32'd9);
    else
      fail_timeout("empty.stamps");

    // ---- timing: back-to-back inputs on the DC instance ----
    sel = 2'd1;
    rd_t.delete();
    wr_t.delete();
    begin
      int nrd;
      nrd = 0;
      @(posedge clk); #1;
      x_in_c = 32'd1024;
      x_empty_c = 1'b0;
      for (int c = 0; c < 300 && nrd < 3; c++) begin
        @(negedge clk);
        if (rd_c) nrd++;
      end
      @(posedge clk); #1;
      x_empty_c = 1'b1;
      if (nrd < 3) fail_timeout("timing.reads");
    end
    wait_outs(12, "timing");
    repeat (2) @(negedge clk);
    chk("timing.nrd", 32'(rd_t.size()), 32'd3);
    chk("timing.nwr", 32'(wr_t.size()), 32'd12);
    if (rd_t.size() == 3) begin
      chk("timing.rd_gap0", 32'(rd_t[1] - rd_t[0]), 32'd37);
      chk("timing.rd_gap1", 32'(rd_t[2] - rd_t[1]), 32'd37);
    end
    if (wr_t.size() == 12) begin
      for (int j = 1; j < 12; j++)
        chk($sformatf("timing.wr_gap%0d", j), 32'(wr_t[j] - wr_t[j-1]),
            (j % 4 == 0) ? 32'd10 : 32'd9);
    end
    for (int j = 0; j < got_q.size(); j++) chk("timing.y", got_q[j], 32'd2048);
    got_q.delete();

    // ---- backpressure: 20 stalled cycles in S_WRITE ----
    full_c = 1'b1;
    feed(32'd1024, "bp");
    repeat (8) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      chk("bp.wr", {31'd0, wr_c}, 32'd0);
      chk("bp.rd", {31'd0, rd_c}, 32'd0);
      chk("bp.y_hold", y_c, 32'd2048);
    end
    chk("bp.nowrites", 32'(got_q.size()), 32'd0);
    @(posedge clk); #1;
    full_c = 1'b0;
    collect_and_check("bp", pack4(2048, 2048, 2048, 2048));

    // ---- reset in S_MAC at k=3, then a clean impulse ----
    sel = 2'd0;
    feed(32'd1024, "pre0");
    collect_and_check("pre0", pack4(4, 6, 8, 10));
    feed(32'd1024, "pre1");
    collect_and_check("pre1", pack4(12, 15, 18, 21));
    feed(32'd1024, "abort");
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete();
    x_in_c = 32'd1024;
    x_empty_c = 1'b0;
    @(negedge clk);
    chk("rst_mac.rd", {31'd0, rd_c}, 32'd1);
    chk("rst_mac.wr", {31'd0, wr_c}, 32'd0);
    chk("rst_mac.y", y_c, 32'd0);
    @(posedge clk); #1;
    x_empty_c = 1'b1;
    collect_and_check("rst_imp0", pack4(0, 1, 2, 3));
    for (int n = 1; n < 8; n++) begin
      feed(32'd0, $sformatf("rst_imp%0d", n));
      collect_and_check($sformatf("rst_imp%0d", n),
                        pack4(32'(4*n), 32'(4*n+1), 32'(4*n+2), 32'(4*n+3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
